// File: rtl/fft_out_unloader_if.sv
// Handshake and data bundle between the FFT output unloader, the result RAM,
// accelerator control and the memory controller.
interface fft_out_unloader_if #(
    parameter int AW = 10
);
    logic            startUnload;
    logic [63:0]     ramRdData;
    logic            ramRdEn;
    logic [AW-1:0]   ramRdAddr;
    logic            accelWrBlkDone;
    logic [511:0]    mcDataOut;
    logic            mcDataOutValid;
    logic            outFifoReady;
    logic            unloading;
    logic            done;

    modport slave (
        input  startUnload, ramRdData, accelWrBlkDone,
        output ramRdEn, ramRdAddr, mcDataOut, mcDataOutValid,
               outFifoReady, unloading, done
    );

    modport master (
        output startUnload, ramRdData, accelWrBlkDone,
        input  ramRdEn, ramRdAddr, mcDataOut, mcDataOutValid,
               outFifoReady, unloading, done
    );
endinterface

// File: rtl/fft_out_unloader.sv
// Drains the FFT result RAM into 512-bit beats, one block at a time, and
// holds each block until the memory controller acknowledges it.
//
// state    | meaning
// S_IDLE   | waiting for startUnload
// S_FILL   | reading one block of samples from RAM into the buffer
// S_STREAM | presenting buffered beats to the memory controller
// S_WAIT   | block sent, waiting for accelWrBlkDone
// S_DONE   | one-cycle done pulse, then back to idle
module fft_out_unloader #(
    parameter int N_SAMPLES = 1024,
    parameter int BLK_BEATS = 8,
    parameter int BIT_REV   = 0
) (
    input  logic               clk,
    input  logic               rst,
    fft_out_unloader_if.slave  bus
);
    localparam int SPB  = 8 * BLK_BEATS;
    localparam int NBLK = N_SAMPLES / SPB;
    localparam int AW   = $clog2(N_SAMPLES);
    localparam int FW   = $clog2(SPB + 1);
    localparam int SW   = $clog2(SPB);
    localparam int BW   = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [KW-1:0]    blk_q, blk_d;
    logic [SPB*64-1:0] buf_q;

    logic             rd_en;
    logic             cap_en;
    logic [SW-1:0]    cap_slot;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            fill_q  <= '0;
            beat_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
        end
    end

    // Buffer needs no reset: its contents are only visible while streaming,
    // and every slot is rewritten during the FILL that precedes a STREAM.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            buf_q[cap_slot*64 +: 64] <= bus.ramRdData;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fill_d   = fill_q;
        beat_d   = beat_q;
        blk_d    = blk_q;
        rd_en    = 1'b0;
        cap_en   = 1'b0;
        cap_slot = SW'(fill_q - FW'(1));

        case (state_q)
            S_IDLE: begin
                if (bus.startUnload) begin
                    state_d = S_FILL;
                    idx_d   = '0;
                    fill_d  = '0;
                    beat_d  = '0;
                    blk_d   = '0;
                end
            end
            S_FILL: begin
                // fill_q counts reads; data for read n lands while fill_q == n+1
                rd_en  = (fill_q != FW'(SPB));
                cap_en = (fill_q != '0);
                if (rd_en) begin
                    idx_d = idx_q + 1'b1;
                end
                if (fill_q == FW'(SPB)) begin
                    state_d = S_STREAM;
                    fill_d  = '0;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            S_STREAM: begin
                if (beat_q == BW'(BLK_BEATS - 1)) begin
                    state_d = S_WAIT;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.accelWrBlkDone) begin
                    if (blk_q == KW'(NBLK - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FILL;
                        blk_d   = blk_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
                fill_d  = '0;
                beat_d  = '0;
                blk_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ramRdEn        = rd_en;
    assign bus.ramRdAddr      = (BIT_REV != 0) ? bitrev(idx_q) : idx_q;
    assign bus.mcDataOutValid = (state_q == S_STREAM);
    assign bus.outFifoReady   = (state_q == S_STREAM) || (state_q == S_WAIT);
    assign bus.unloading      = (state_q != S_IDLE);
    assign bus.done           = (state_q == S_DONE);
    assign bus.mcDataOut      = (state_q == S_STREAM) ? buf_q[beat_q*512 +: 512] : '0;
endmodule

// File: tb/tb_fft_out_unloader.sv
// Self-checking bench for fft_out_unloader: full unloads against a sample-level
// reference, latency, early/late acknowledge, reset mid-run and bit-reversed addressing.
module tb_fft_out_unloader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_out_unloader_if #(.AW(10)) bus ();
    fft_out_unloader_if #(.AW(10)) bus_br ();

    fft_out_unloader #(.N_SAMPLES(1024), .BLK_BEATS(8), .BIT_REV(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    fft_out_unloader #(.N_SAMPLES(1024), .BLK_BEATS(8), .BIT_REV(1)) dut_br (
        .clk (clk),
        .rst (rst),
        .bus (bus_br.slave)
    );

    int tests = 0;
    int fails = 0;

    // Result RAM model: sample at address a is {a, ~a}; garbage when not read.
    always @(posedge clk) begin
        if (bus.ramRdEn) bus.ramRdData <= {22'd0, bus.ramRdAddr, ~{22'd0, bus.ramRdAddr}};
        else             bus.ramRdData <= 64'hDEAD_BEEF_0BAD_F00D;
    end
    assign bus_br.ramRdData      = 64'd0;
    assign bus_br.accelWrBlkDone = 1'b0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat k of the whole signal holds samples 8k..8k+7, earliest in the low bits.
    function automatic logic [511:0] exp_beat(input int k);
        logic [511:0] r;
        logic [31:0]  id;
        for (int j = 0; j < 8; j++) begin
            id = 32'(8 * k + j);
            r[64*j +: 64] = {id, ~id};
        end
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_rden"},  bus.ramRdEn, 0);
        check({tag, "_addr"},  bus.ramRdAddr, 0);
        check({tag, "_data"},  bus.mcDataOut, 0);
        check({tag, "_valid"}, bus.mcDataOutValid, 0);
        check({tag, "_ready"}, bus.outFifoReady, 0);
        check({tag, "_busy"},  bus.unloading, 0);
        check({tag, "_done"},  bus.done, 0);
    endtask

    task automatic run_full(input bit with_br);
        int c = 0, beats = 0, runs = 0, run_len = 0, first_valid = -1;
        int ack_due = -1, acks = 0, last_ack_c = -1, done_cnt = 0, done_c = -1;
        int rd_cnt = 0, addr_errs = 0, run_errs = 0;
        int br_exp[4] = '{0, 512, 256, 768};
        bit prev_valid = 0, early_sent = 0, finished = 0;
        @(negedge clk);
        bus.startUnload    = 1'b1;
        bus_br.startUnload = with_br;
        while (!finished && c < 5000) begin
            @(negedge clk);
            c++;
            bus.startUnload    = (c == 10);
            bus_br.startUnload = 1'b0;
            bus.accelWrBlkDone = 1'b0;
            if (c == 1) begin
                check("first_rden", bus.ramRdEn, 1);
                check("first_addr", bus.ramRdAddr, 0);
            end
            if (with_br && c >= 1 && c <= 4)
                check($sformatf("bitrev_addr%0d", c - 1), bus_br.ramRdAddr, br_exp[c-1]);
            if (bus.ramRdEn) begin
                if (bus.ramRdAddr !== 10'(rd_cnt)) addr_errs++;
                rd_cnt++;
            end
            if (bus.mcDataOutValid) begin
                if (first_valid < 0) first_valid = c;
                check($sformatf("beat%0d", beats), bus.mcDataOut, exp_beat(beats));
                beats++;
                run_len++;
                if (beats == 4 && !early_sent) begin
                    bus.accelWrBlkDone = 1'b1;
                    early_sent = 1'b1;
                end
            end else if (prev_valid) begin
                runs++;
                if (run_len != 8) run_errs++;
                run_len = 0;
                check($sformatf("wait_ready%0d", runs), bus.outFifoReady, 1);
                check($sformatf("wait_rden%0d", runs), bus.ramRdEn, 0);
                ack_due = c + 2;
            end
            prev_valid = bus.mcDataOutValid;
            if (c == last_ack_c + 1 && acks < 16) begin
                check($sformatf("refill_rden%0d", acks), bus.ramRdEn, 1);
                check($sformatf("refill_addr%0d", acks), bus.ramRdAddr, 64 * acks);
            end
            if (c == ack_due) begin
                bus.accelWrBlkDone = 1'b1;
                acks++;
                last_ack_c = c;
            end
            if (bus.done) begin
                done_cnt++;
                done_c = c;
                check("done_busy", bus.unloading, 1);
            end
            if (done_c >= 0 && c > done_c + 3) finished = 1'b1;
        end
        bus.startUnload    = 1'b0;
        bus.accelWrBlkDone = 1'b0;
        check("finished_in_budget", finished, 1);
        check("first_valid_latency", first_valid, 66);
        check("beat_count", beats, 128);
        check("block_count", runs, 16);
        check("run_len_errs", run_errs, 0);
        check("read_count", rd_cnt, 1024);
        check("addr_errs", addr_errs, 0);
        check("done_count", done_cnt, 1);
        check("done_after_last_ack", done_c, last_ack_c + 1);
        check("idle_after_done", bus.unloading, 0);
    endtask

    task automatic run_reset_mid();
        int c = 0, beats = 0, stray = 0;
        bit hit = 0;
        @(negedge clk);
        bus.startUnload = 1'b1;
        while (!hit && c < 2000) begin
            @(negedge clk);
            c++;
            bus.startUnload    = 1'b0;
            bus.accelWrBlkDone = 1'b0;
            if (bus.mcDataOutValid) begin
                beats++;
                if (beats == 5 * 8 + 3) begin
                    rst = 1'b1;
                    hit = 1'b1;
                end
            end else if (bus.outFifoReady) begin
                bus.accelWrBlkDone = 1'b1;
            end
        end
        check("reset_point_reached", hit, 1);
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrst");
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.unloading) stray++;
        end
        check("no_done_after_rst", stray, 0);
    endtask

    initial begin
        rst                = 1'b1;
        bus.startUnload    = 1'b0;
        bus.accelWrBlkDone = 1'b0;
        bus_br.startUnload = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        bus.accelWrBlkDone = 1'b1;
        @(negedge clk);
        bus.accelWrBlkDone = 1'b0;
        @(negedge clk);
        check("idle_ack_busy", bus.unloading, 0);
        check("idle_ack_ready", bus.outFifoReady, 0);

        run_full(1'b1);

        run_reset_mid();

        rst             = 1'b1;
        bus.startUnload = 1'b1;
        @(negedge clk);
        rst             = 1'b0;
        bus.startUnload = 1'b0;
        check("rst_wins_busy", bus.unloading, 0);
        check("rst_wins_rden", bus.ramRdEn, 0);
        @(negedge clk);

        run_full(1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
